// File: rtl/posit_encoder_pipe.sv
// posit_encoder_pipe: three-stage pipelined posit encoder.
// Takes a decoded posit (sign/scale/fraction/GRS/zero/NaR) and packs it into
// a POSIT_WIDTH-bit posit with rounding, minpos/maxpos saturation and
// two's-complement negation. Valid/ready streaming with a global stall.
// Build option: define POSIT_ENC_RNE_EN for round-to-nearest-even; otherwise
// the magnitude is truncated toward zero.
module posit_encoder_pipe #(
  parameter int POSIT_WIDTH = 8,
  parameter int POSIT_ES    = 0,
  parameter int SCALE_W     = $clog2((POSIT_WIDTH - 1) << POSIT_ES) + 1,
  parameter int FRAC_W      = POSIT_WIDTH - 3 - POSIT_ES
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_sign,
  input  logic                      in_zero,
  input  logic                      in_nar,
  input  logic signed [SCALE_W-1:0] in_scale,
  input  logic [FRAC_W-1:0]         in_fraction,
  input  logic                      in_guard,
  input  logic                      in_round,
  input  logic                      in_sticky,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [POSIT_WIDTH-1:0]    out_posit
);

  localparam int N         = POSIT_WIDTH;
  localparam int ES        = POSIT_ES;
  localparam int ES_W      = (ES > 0) ? ES : 1;
  localparam int T         = ES + FRAC_W + 3;    // exponent+fraction+GRS bits
  localparam int TX        = ES_W + FRAC_W + 3;  // same, with one padding bit when ES==0
  localparam int WB        = N + ES + FRAC_W + 3; // longest regime plus full tail
  localparam int REM_W     = WB - (N - 1);
  localparam int MAX_SCALE = (N - 2) << ES;

`ifdef POSIT_ENC_RNE_EN
  localparam bit RNE_EN = 1'b1;
`else
  localparam bit RNE_EN = 1'b0;
`endif

  logic en_s;

  // stage 1 registers
  logic                      s1_valid_r, s1_sign_r, s1_zero_r, s1_nar_r;
  logic                      s1_sat_hi_r, s1_sat_lo_r;
  logic signed [SCALE_W-1:0] s1_k_r;
  logic [ES_W-1:0]           s1_e_r;
  logic [FRAC_W-1:0]         s1_frac_r;
  logic                      s1_g_r, s1_r_r, s1_s_r;

  // stage 2 registers
  logic                      s2_valid_r, s2_sign_r, s2_zero_r, s2_nar_r;
  logic                      s2_sat_hi_r, s2_sat_lo_r;
  logic [N-1:0]              s2_mag_r;

  // stage 1 combinational
  int                        scale_s, clamp_s;
  logic                      sat_hi_s, sat_lo_s;
  logic signed [SCALE_W-1:0] k_s;
  logic [ES_W-1:0]           e_s;

  // stage 2 combinational
  int                        k_int_s, rl_s;
  logic [WB-1:0]             regime_s, tail_s, body_s;
  logic [N-2:0]              window_s;
  logic [REM_W-1:0]          rem_s;
  logic                      guard_s, sticky_s, up_s;
  logic [N-1:0]              mag_s;

  // stage 3 combinational
  logic [N-2:0]              fix_s;
  logic [N-1:0]              posit_s;

  // a stage advances only when the output register is free or draining
  assign en_s     = ~out_valid | out_ready;
  assign in_ready = en_s;

  // clamp the scale to the representable range and split it into regime k and exponent e
  always_comb begin
    scale_s  = int'(in_scale);
    sat_hi_s = 1'b0;
    sat_lo_s = 1'b0;
    if (scale_s > MAX_SCALE) begin
      clamp_s  = MAX_SCALE;
      sat_hi_s = 1'b1;
    end else if (scale_s < -MAX_SCALE) begin
      clamp_s  = -MAX_SCALE;
      sat_lo_s = 1'b1;
    end else begin
      clamp_s  = scale_s;
    end
    k_s = SCALE_W'(clamp_s >>> ES);
    if (ES > 0) begin
      e_s = clamp_s[ES_W-1:0];
    end else begin
      e_s = {ES_W{1'b0}};
    end
  end

  // stage 1 register: clamped scale fields and pass-through of specials
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_r  <= 1'b0;
      s1_sign_r   <= 1'b0;
      s1_zero_r   <= 1'b0;
      s1_nar_r    <= 1'b0;
      s1_sat_hi_r <= 1'b0;
      s1_sat_lo_r <= 1'b0;
      s1_k_r      <= {SCALE_W{1'b0}};
      s1_e_r      <= {ES_W{1'b0}};
      s1_frac_r   <= {FRAC_W{1'b0}};
      s1_g_r      <= 1'b0;
      s1_r_r      <= 1'b0;
      s1_s_r      <= 1'b0;
    end else if (en_s) begin
      s1_valid_r  <= in_valid;
      s1_sign_r   <= in_sign;
      s1_zero_r   <= in_zero;
      s1_nar_r    <= in_nar;
      s1_sat_hi_r <= sat_hi_s;
      s1_sat_lo_r <= sat_lo_s;
      s1_k_r      <= k_s;
      s1_e_r      <= e_s;
      s1_frac_r   <= in_fraction;
      s1_g_r      <= in_guard;
      s1_r_r      <= in_round;
      s1_s_r      <= in_sticky;
    end
  end

  // build regime + tail left-aligned, cut the N-1 bit window and round on the folded remainder
  always_comb begin
    k_int_s = int'(s1_k_r);
    if (k_int_s >= 0) begin
      rl_s     = k_int_s + 2;
      regime_s = ~({WB{1'b1}} >> (k_int_s + 1));
    end else begin
      rl_s     = 1 - k_int_s;
      regime_s = {{(WB - 1){1'b0}}, 1'b1} << (WB - rl_s);
    end
    // with ES==0 the zero padding bit at the top of the tail lands on the regime terminator
    tail_s   = {{(WB - TX){1'b0}}, s1_e_r, s1_frac_r, s1_g_r, s1_r_r, s1_s_r};
    body_s   = regime_s | (tail_s << (WB - rl_s - T));
    window_s = body_s[WB-1 -: (N - 1)];
    rem_s    = body_s[REM_W-1:0];
    guard_s  = rem_s[REM_W-1];
    sticky_s = |rem_s[REM_W-2:0];
    up_s     = RNE_EN & guard_s & (sticky_s | window_s[0]);
    mag_s    = {1'b0, window_s} + {{(N - 1){1'b0}}, up_s};
  end

  // stage 2 register: rounded magnitude with its carry-out
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_r  <= 1'b0;
      s2_sign_r   <= 1'b0;
      s2_zero_r   <= 1'b0;
      s2_nar_r    <= 1'b0;
      s2_sat_hi_r <= 1'b0;
      s2_sat_lo_r <= 1'b0;
      s2_mag_r    <= {N{1'b0}};
    end else if (en_s) begin
      s2_valid_r  <= s1_valid_r;
      s2_sign_r   <= s1_sign_r;
      s2_zero_r   <= s1_zero_r;
      s2_nar_r    <= s1_nar_r;
      s2_sat_hi_r <= s1_sat_hi_r;
      s2_sat_lo_r <= s1_sat_lo_r;
      s2_mag_r    <= mag_s;
    end
  end

  // saturate to maxpos/minpos, then apply specials and sign
  always_comb begin
    if (s2_sat_hi_r | s2_mag_r[N-1]) begin
      fix_s = {(N - 1){1'b1}};
    end else if (s2_sat_lo_r | (s2_mag_r[N-2:0] == {(N - 1){1'b0}})) begin
      fix_s = {{(N - 2){1'b0}}, 1'b1};
    end else begin
      fix_s = s2_mag_r[N-2:0];
    end
    if (s2_nar_r) begin
      posit_s = {1'b1, {(N - 1){1'b0}}};
    end else if (s2_zero_r) begin
      posit_s = {N{1'b0}};
    end else if (s2_sign_r) begin
      posit_s = ~{1'b0, fix_s} + {{(N - 1){1'b0}}, 1'b1};
    end else begin
      posit_s = {1'b0, fix_s};
    end
  end

  // stage 3 register: the output beat, held while downstream stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_posit <= {N{1'b0}};
    end else if (en_s) begin
      out_valid <= s2_valid_r;
      out_posit <= posit_s;
    end
  end

endmodule

// File: tb/tb_posit_encoder_pipe.sv
// Scoreboard bench for posit_encoder_pipe at N=8, ES=0.
module tb_posit_encoder_pipe;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid, in_ready;
  logic              in_sign, in_zero, in_nar;
  logic signed [3:0] in_scale;
  logic [4:0]        in_fraction;
  logic              in_guard, in_round, in_sticky;
  logic              out_valid, out_ready;
  logic [7:0]        out_posit;

  typedef struct {
    logic              sign, zero, nar;
    logic signed [3:0] scale;
    logic [4:0]        frac;
    logic              g, r, s;
    logic [7:0]        e_rne, e_trn;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] sb[$];
  logic [7:0] exp_m;
  int         n_checks = 0;
  int         n_fail   = 0;
  logic       drv_done;

  posit_encoder_pipe dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_zero(in_zero), .in_nar(in_nar),
    .in_scale(in_scale), .in_fraction(in_fraction),
    .in_guard(in_guard), .in_round(in_round), .in_sticky(in_sticky),
    .out_valid(out_valid), .out_ready(out_ready), .out_posit(out_posit)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  function automatic void addv(input logic sg, input logic zr, input logic nr,
                               input logic signed [3:0] sc, input logic [4:0] fr,
                               input logic [2:0] grs, input logic [7:0] er, input logic [7:0] et);
    vec_t v;
    v.sign = sg; v.zero = zr; v.nar = nr; v.scale = sc; v.frac = fr;
    v.g = grs[2]; v.r = grs[1]; v.s = grs[0];
    v.e_rne = er; v.e_trn = et;
    vecs.push_back(v);
  endfunction

  function automatic logic [7:0] exp_of(input vec_t v);
`ifdef POSIT_ENC_RNE_EN
    return v.e_rne;
`else
    return v.e_trn;
`endif
  endfunction

  task automatic drive(input vec_t v);
    in_sign = v.sign; in_zero = v.zero; in_nar = v.nar; in_scale = v.scale;
    in_fraction = v.frac; in_guard = v.g; in_round = v.r; in_sticky = v.s;
  endtask

  // present a beat until accepted (bounded), recording the expected result on acceptance
  task automatic send(input vec_t v);
    bit done = 1'b0;
    drive(v);
    in_valid = 1'b1;
    for (int t = 0; t < 100 && !done; t++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(exp_of(v));
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      n_checks++; n_fail++;
      $display("FAIL send_timeout: got in_ready=0 expected acceptance within 100 cycles");
    end
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("drain_empty", sb.size(), 0);
    @(posedge clk); #1;
  endtask

  // monitor: every delivered beat must match the oldest expected result
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_beat: got 0x%0h expected none", out_posit);
      end else begin
        exp_m = sb.pop_front();
        check("posit", out_posit, exp_m);
      end
    end
  end

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         lat;
    bit         got;
    logic [3:0] acc;
    int         bp[4];

    // sign zero nar scale frac grs rne trunc
    addv(1'b0, 1'b0, 1'b0,  4'sd0, 5'b00000, 3'b000, 8'h40, 8'h40);
    addv(1'b0, 1'b0, 1'b0,  4'sd0, 5'b10000, 3'b000, 8'h50, 8'h50);
    addv(1'b1, 1'b0, 1'b0,  4'sd0, 5'b00000, 3'b000, 8'hC0, 8'hC0);
    addv(1'b0, 1'b0, 1'b0,  4'sd6, 5'b00000, 3'b000, 8'h7F, 8'h7F);
    addv(1'b0, 1'b0, 1'b0,  4'sd7, 5'b00000, 3'b000, 8'h7F, 8'h7F);
    addv(1'b0, 1'b0, 1'b0, -4'sd6, 5'b00000, 3'b000, 8'h01, 8'h01);
    addv(1'b0, 1'b0, 1'b0, -4'sd8, 5'b11111, 3'b111, 8'h01, 8'h01);
    addv(1'b0, 1'b0, 1'b1,  4'sd0, 5'b00000, 3'b000, 8'h80, 8'h80);
    addv(1'b0, 1'b1, 1'b0,  4'sd0, 5'b00000, 3'b000, 8'h00, 8'h00);
    addv(1'b1, 1'b1, 1'b1,  4'sd2, 5'b10101, 3'b000, 8'h80, 8'h80);
    addv(1'b1, 1'b1, 1'b0,  4'sd3, 5'b00000, 3'b000, 8'h00, 8'h00);
    addv(1'b0, 1'b0, 1'b0,  4'sd0, 5'b00000, 3'b100, 8'h40, 8'h40);
    addv(1'b0, 1'b0, 1'b0,  4'sd0, 5'b00000, 3'b101, 8'h41, 8'h40);
    addv(1'b0, 1'b0, 1'b0,  4'sd0, 5'b11111, 3'b110, 8'h60, 8'h5F);
    addv(1'b0, 1'b0, 1'b0,  4'sd3, 5'b10110, 3'b000, 8'h7B, 8'h7A);
    addv(1'b0, 1'b0, 1'b0,  4'sd3, 5'b10100, 3'b000, 8'h7A, 8'h7A);
    addv(1'b0, 1'b0, 1'b0,  4'sd3, 5'b11100, 3'b000, 8'h7C, 8'h7B);
    addv(1'b1, 1'b0, 1'b0,  4'sd3, 5'b10110, 3'b000, 8'h85, 8'h86);
    addv(1'b1, 1'b0, 1'b0,  4'sd0, 5'b10000, 3'b000, 8'hB0, 8'hB0);
    addv(1'b0, 1'b0, 1'b0, -4'sd6, 5'b10000, 3'b000, 8'h02, 8'h01);
    addv(1'b0, 1'b0, 1'b0, -4'sd5, 5'b00000, 3'b000, 8'h02, 8'h02);
    addv(1'b0, 1'b0, 1'b0,  4'sd5, 5'b11111, 3'b111, 8'h7F, 8'h7E);
    addv(1'b0, 1'b0, 1'b0,  4'sd6, 5'b11111, 3'b111, 8'h7F, 8'h7F);
    addv(1'b0, 1'b0, 1'b0, -4'sd1, 5'b01000, 3'b000, 8'h28, 8'h28);
    addv(1'b0, 1'b0, 1'b0,  4'sd2, 5'b00001, 3'b011, 8'h70, 8'h70);

    // reset state
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; drv_done = 1'b0;
    drive(vecs[0]);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_posit", out_posit, 8'h00);
    @(posedge clk); #1;

    // latency of a single beat
    drive(vecs[0]);
    in_valid = 1'b1;
    @(negedge clk);
    check("lat_accept", in_ready, 1);
    sb.push_back(exp_of(vecs[0]));
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0; got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge clk);
      lat++;
      if (out_valid) got = 1'b1;
      else @(posedge clk);
    end
    check("latency", lat, 3);
    @(posedge clk); #1;

    // back-to-back stream with free-running sink
    foreach (vecs[i]) send(vecs[i]);
    drain();

    // backpressure: four beats against a stalled sink
    bp[0] = 1; bp[1] = 2; bp[2] = 5; bp[3] = 6;
    out_ready = 1'b0;
    acc = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      drive(vecs[bp[i]]);
      in_valid = 1'b1;
      @(negedge clk);
      acc[i] = in_ready;
      if (in_ready) sb.push_back(exp_of(vecs[bp[i]]));
      @(posedge clk); #1;
    end
    check("bp_accepted", acc, 4'b0111);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_in_ready", in_ready, 0);
      check("bp_out_valid", out_valid, 1);
      check("bp_hold_posit", out_posit, exp_of(vecs[bp[0]]));
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    send(vecs[bp[3]]);
    drain();

    // random sink readiness over the full vector list, twice
    for (int pass = 0; pass < 2; pass++) begin
      drv_done = 1'b0;
      fork
        begin
          foreach (vecs[i]) send(vecs[i]);
          drv_done = 1'b1;
        end
        begin
          while (!drv_done) begin
            @(posedge clk); #1;
            out_ready = ($urandom_range(0, 1) == 1);
          end
        end
      join
      out_ready = 1'b1;
      drain();
    end

    // reset with two beats in flight
    send(vecs[0]);
    send(vecs[2]);
    rst = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("flush_out_valid", out_valid, 0);
    check("flush_out_posit", out_posit, 8'h00);
    check("flush_in_ready", in_ready, 1);
    repeat (8) @(posedge clk);
    #1;
    check("flush_no_stale", sb.size(), 0);

    // pipeline still usable after the flush
    send(vecs[17]);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
